// File: rtl/riscv_tb_pkg.sv
// Shared run-controller types: FSM state encoding and the default
// tohost mailbox address.
package riscv_tb_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } run_state_e;

    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;

    function automatic logic is_terminal(input run_state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high clear.
// Used for the run-cycle and retired-instruction counters.
module sat_counter
    import riscv_tb_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Advance when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sim_run_controller.sv
// Sequences core reset, watches the tohost mailbox and a watchdog.
// Define RUN_CTRL_INSTRET_EN to add the retired-instruction counter.
module sim_run_controller
    import riscv_tb_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned CNT_W       = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    input  logic             retire_valid,
    output logic             core_rst,
    output logic             core_en,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [XLEN-2:0]  fail_code,
    output logic [CNT_W-1:0] cycle_cnt
`ifdef RUN_CTRL_INSTRET_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    localparam int unsigned RW =
        ($clog2(RST_CYCLES + 1) > 0) ? $clog2(RST_CYCLES + 1) : 1;

    run_state_e state_q, state_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [XLEN-2:0] fail_code_q, fail_code_d;
    logic core_rst_q, core_en_q, done_q, pass_q, timeout_q;
    logic mbox;
    logic wd_hit;
    logic in_run;

    assign in_run = (state_q == ST_RUN);
    assign mbox   = in_run && st_valid && (st_addr == TOHOST_ADDR);
    assign wd_hit = (64'(cycle_cnt) == 64'(MAX_CYCLES - 1));

    // Next state, reset-hold counter and captured failure code.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        fail_code_d = fail_code_q;
        unique case (state_q)
            ST_RESET: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if ((RST_CYCLES <= 1) ||
                    (32'(rst_cnt_q) == RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mbox && (st_data == XLEN'(1))) begin
                    state_d = ST_PASS;
                end else if (mbox && st_data[0]) begin
                    state_d     = ST_FAIL;
                    fail_code_d = st_data[XLEN-1:1];
                end else if (wd_hit) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= '0;
            fail_code_q <= '0;
            core_rst_q  <= 1'b1;
            core_en_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            fail_code_q <= fail_code_d;
            core_rst_q  <= (state_d == ST_RESET);
            core_en_q   <= (state_d == ST_RUN);
            done_q      <= is_terminal(state_d);
            pass_q      <= (state_d == ST_PASS);
            timeout_q   <= (state_d == ST_TIMEOUT);
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (in_run),
        .cnt (cycle_cnt)
    );

`ifdef RUN_CTRL_INSTRET_EN
    sat_counter #(.W(CNT_W)) u_instret (
        .clk (clk),
        .rst (rst),
        .en  (in_run && retire_valid),
        .cnt (instret)
    );
`else
    logic unused_retire;
    assign unused_retire = retire_valid;
`endif

    assign core_rst  = core_rst_q;
    assign core_en   = core_en_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign fail_code = fail_code_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: reset sequencing, mailbox
// pass/fail, watchdog, reset pulses and counter saturation.
module tb_sim_run_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        retire_valid = 1'b0;

    logic        a_core_rst, a_core_en, a_done, a_pass, a_timeout;
    logic [30:0] a_fail_code;
    logic [31:0] a_cycle_cnt;
    logic        b_core_rst, b_core_en, b_done, b_pass, b_timeout;
    logic [30:0] b_fail_code;
    logic [3:0]  b_cycle_cnt;
`ifdef RUN_CTRL_INSTRET_EN
    logic [31:0] a_instret;
    logic [3:0]  b_instret;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sim_run_controller #(.MAX_CYCLES(50)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .retire_valid (retire_valid),
        .core_rst     (a_core_rst),
        .core_en      (a_core_en),
        .done         (a_done),
        .pass         (a_pass),
        .timeout      (a_timeout),
        .fail_code    (a_fail_code),
        .cycle_cnt    (a_cycle_cnt)
`ifdef RUN_CTRL_INSTRET_EN
        ,
        .instret      (a_instret)
`endif
    );

    sim_run_controller #(.RST_CYCLES(0), .CNT_W(4)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .retire_valid (retire_valid),
        .core_rst     (b_core_rst),
        .core_en      (b_core_en),
        .done         (b_done),
        .pass         (b_pass),
        .timeout      (b_timeout),
        .fail_code    (b_fail_code),
        .cycle_cnt    (b_cycle_cnt)
`ifdef RUN_CTRL_INSTRET_EN
        ,
        .instret      (b_instret)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".core_rst"}, 64'(a_core_rst), 64'd1);
        chk({tag, ".core_en"}, 64'(a_core_en), 64'd0);
        chk({tag, ".done"}, 64'(a_done), 64'd0);
        chk({tag, ".pass"}, 64'(a_pass), 64'd0);
        chk({tag, ".timeout"}, 64'(a_timeout), 64'd0);
        chk({tag, ".cycle_cnt"}, 64'(a_cycle_cnt), 64'd0);
        chk({tag, ".fail_code"}, 64'(a_fail_code), 64'd0);
    endtask

    initial begin
        // Reset held 4 clocks, then the 4-clock core reset sequence.
        @(negedge clk);
        tick(4);
        chk_reset_vals("rst_hold");
        chk("b_rst_hold.core_rst", 64'(b_core_rst), 64'd1);
        rst = 1'b0;
        tick(1);
        chk("seq1.core_rst", 64'(a_core_rst), 64'd1);
        chk("b_rst0.core_en", 64'(b_core_en), 64'd1);
        chk("b_rst0.core_rst", 64'(b_core_rst), 64'd0);
        tick(2);
        chk("seq3.core_rst", 64'(a_core_rst), 64'd1);
        chk("seq3.core_en", 64'(a_core_en), 64'd0);
        tick(1);
        chk("seq4.core_en", 64'(a_core_en), 64'd1);
        chk("seq4.core_rst", 64'(a_core_rst), 64'd0);
        chk("seq4.cycle_cnt", 64'(a_cycle_cnt), 64'd0);

        // Pass write while cycle_cnt reads 20.
        tick(20);
        chk("run20.cycle_cnt", 64'(a_cycle_cnt), 64'd20);
        chk("b_sat.cycle_cnt", 64'(b_cycle_cnt), 64'd15);
        chk("b_sat.done", 64'(b_done), 64'd0);
        store(32'h1000, 32'h1);
        tick(1);
        st_valid = 1'b0;
        chk("pass.done", 64'(a_done), 64'd1);
        chk("pass.pass", 64'(a_pass), 64'd1);
        chk("pass.core_en", 64'(a_core_en), 64'd0);
        chk("pass.core_rst", 64'(a_core_rst), 64'd0);
        chk("pass.timeout", 64'(a_timeout), 64'd0);
        chk("pass.cycle_cnt", 64'(a_cycle_cnt), 64'd21);
        tick(5);
        chk("pass_frz.cycle_cnt", 64'(a_cycle_cnt), 64'd21);
        chk("pass_frz.pass", 64'(a_pass), 64'd1);

        // One-clock reset pulse in PASS restarts the sequence.
        rst = 1'b1;
        tick(1);
        chk_reset_vals("rst_in_pass");
        rst = 1'b0;
        tick(3);
        chk("restart3.core_rst", 64'(a_core_rst), 64'd1);
        tick(1);
        chk("restart4.core_en", 64'(a_core_en), 64'd1);

        // Even data and a wrong address are ignored; 7 fails with code 3.
        tick(3);
        store(32'h1000, 32'h2);
        tick(1);
        chk("even.done", 64'(a_done), 64'd0);
        chk("even.core_en", 64'(a_core_en), 64'd1);
        store(32'h1004, 32'h1);
        tick(1);
        chk("badaddr.done", 64'(a_done), 64'd0);
        store(32'h1000, 32'h7);
        tick(1);
        st_valid = 1'b0;
        chk("fail.done", 64'(a_done), 64'd1);
        chk("fail.pass", 64'(a_pass), 64'd0);
        chk("fail.timeout", 64'(a_timeout), 64'd0);
        chk("fail.fail_code", 64'(a_fail_code), 64'd3);
        chk("fail.core_en", 64'(a_core_en), 64'd0);
        chk("fail.cycle_cnt", 64'(a_cycle_cnt), 64'd6);
        store(32'h1000, 32'h1);
        tick(1);
        st_valid = 1'b0;
        chk("fail_term.pass", 64'(a_pass), 64'd0);
        chk("fail_term.fail_code", 64'(a_fail_code), 64'd3);

        // Reset out of FAIL, then a reset pulse mid-RUN.
        rst = 1'b1;
        tick(1);
        chk_reset_vals("rst_in_fail");
        rst = 1'b0;
        tick(4);
        tick(5);
        chk("midrun.cycle_cnt", 64'(a_cycle_cnt), 64'd5);
        rst = 1'b1;
        tick(1);
        chk_reset_vals("rst_midrun");

        // A pass write during the core reset window is ignored.
        rst = 1'b0;
        store(32'h1000, 32'h1);
        tick(1);
        st_valid = 1'b0;
        tick(3);
        chk("rstwin.done", 64'(a_done), 64'd0);
        chk("rstwin.core_en", 64'(a_core_en), 64'd1);
        chk("rstwin.b_done", 64'(b_done), 64'd0);

        // Watchdog with no mailbox write.
        retire_valid = 1'b1;
        tick(49);
        chk("wd49.timeout", 64'(a_timeout), 64'd0);
        chk("wd49.cycle_cnt", 64'(a_cycle_cnt), 64'd49);
        tick(1);
        retire_valid = 1'b0;
        chk("wd.timeout", 64'(a_timeout), 64'd1);
        chk("wd.done", 64'(a_done), 64'd1);
        chk("wd.pass", 64'(a_pass), 64'd0);
        chk("wd.core_en", 64'(a_core_en), 64'd0);
        chk("wd.cycle_cnt", 64'(a_cycle_cnt), 64'd50);
        chk("wd.b_cycle_cnt", 64'(b_cycle_cnt), 64'd15);
        chk("wd.b_done", 64'(b_done), 64'd0);
`ifdef RUN_CTRL_INSTRET_EN
        chk("wd.instret", 64'(a_instret), 64'd50);
        chk("wd.b_instret", 64'(b_instret), 64'd15);
`endif
        tick(3);
        chk("wd_frz.cycle_cnt", 64'(a_cycle_cnt), 64'd50);
`ifdef RUN_CTRL_INSTRET_EN
        chk("wd_frz.instret", 64'(a_instret), 64'd50);
`endif

        // Pass write on the watchdog clock: mailbox wins.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        tick(49);
        store(32'h1000, 32'h1);
        tick(1);
        st_valid = 1'b0;
        chk("race.pass", 64'(a_pass), 64'd1);
        chk("race.timeout", 64'(a_timeout), 64'd0);
        chk("race.done", 64'(a_done), 64'd1);
        chk("race.cycle_cnt", 64'(a_cycle_cnt), 64'd50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sim_run_controller.md
SIM_RUN_CONTROLLER -- requirements
Module: sim_run_controller

Interface
REQ-001 Parameter XLEN, default 32, data/address width of the monitored store port.
REQ-002 Parameter RST_CYCLES, default 4, clocks core_rst is held after rst deasserts; 0 is legal.
REQ-003 Parameter MAX_CYCLES, default 1000, RUN-state watchdog limit in clocks; minimum 1.
REQ-004 Parameter CNT_W, default 32, width of cycle_cnt (and instret when enabled).
REQ-005 Parameter TOHOST_ADDR, default 32'h0000_1000, store address treated as the test-result mailbox.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 st_valid  input  1  core data-memory store strobe, one transfer per high cycle.
REQ-009 st_addr  input  XLEN  store byte address.
REQ-010 st_data  input  XLEN  store data.
REQ-011 retire_valid  input  1  one instruction retired this cycle (used only with RUN_CTRL_INSTRET_EN).
REQ-012 core_rst  output  1  reset driven to the core under test.
REQ-013 core_en  output  1  core clock-enable; 0 halts the core.
REQ-014 done  output  1  run finished (pass, fail or timeout), sticky.
REQ-015 pass  output  1  run passed; valid when done=1.
REQ-016 timeout  output  1  watchdog expired; valid when done=1.
REQ-017 fail_code  output  XLEN-1  st_data[XLEN-1:1] of a failing mailbox write.
REQ-018 cycle_cnt  output  CNT_W  clocks spent in RUN.
REQ-019 instret  output  CNT_W  retired-instruction count (present only with RUN_CTRL_INSTRET_EN).

Function
REQ-020 FSM states SHALL be RESET, RUN, PASS, FAIL, TIMEOUT; PASS/FAIL/TIMEOUT are terminal until rst.
REQ-021 RESET: core_rst=1, core_en=0, rst_cnt increments; exit to RUN on the clock where rst_cnt==RST_CYCLES-1 (RST_CYCLES=0: RUN on first clock after rst deasserts).
REQ-022 RUN: core_rst=0, core_en=1, cycle_cnt increments by 1 each clock, saturating at all-ones.
REQ-023 Mailbox write = st_valid=1 and st_addr==TOHOST_ADDR in RUN; writes in any other state or address SHALL be ignored.
REQ-024 Mailbox with st_data==1 -> PASS next clock; st_data[0]==1 and st_data!=1 -> FAIL, fail_code=st_data[XLEN-1:1]; st_data[0]==0 -> ignored, stay RUN.
REQ-025 Watchdog: RUN with cycle_cnt==MAX_CYCLES-1 and no valid mailbox write -> TIMEOUT next clock (cycle_cnt then equals MAX_CYCLES).
REQ-026 Simultaneous mailbox write and watchdog expiry: mailbox result SHALL win.
REQ-027 Terminal states: core_rst=0, core_en=0, done=1, cycle_cnt and fail_code frozen; pass=1 only in PASS, timeout=1 only in TIMEOUT.
REQ-028 All outputs SHALL be registered; outputs reflect state one clock after the causing input.

Reset
REQ-029 rst=1 SHALL force state=RESET, rst_cnt=0, cycle_cnt=0, instret=0, fail_code=0, core_rst=1, core_en=0, done=0, pass=0, timeout=0, from any state including mid-RUN and terminal.
REQ-030 Holding rst high SHALL keep core_rst=1 regardless of RST_CYCLES; counting starts only after rst deasserts.

Configuration
REQ-031 Macro RUN_CTRL_INSTRET_EN defined: instret port and counter exist; in RUN, increments on retire_valid=1, saturating; frozen in terminal states.
REQ-032 Macro undefined: instret port and counter absent, retire_valid ignored; all other behaviour identical.

Structure
REQ-033 FSM state encoding and the default TOHOST_ADDR constant SHALL live in shared package riscv_tb_pkg.
REQ-034 cycle_cnt and instret SHALL each instantiate sub-module sat_counter (parameter W; inputs clk, rst, en; output cnt, saturating at all-ones).

Verification
REQ-035 Defaults; rst 4 clocks then low -> core_rst=1 for 4 more clocks, core_en=1 from 5th clock after rst falls.
REQ-036 Store addr 0x1000 data 1 at RUN clock 20 -> next clock done=1, pass=1, core_en=0, cycle_cnt=21 and frozen.
REQ-037 Store addr 0x1000 data 0x0000_0007 -> FAIL, fail_code=3, pass=0; prior store data 0x2 to 0x1000 ignored.
REQ-038 MAX_CYCLES=50, no mailbox -> TIMEOUT with cycle_cnt=50; repeat with pass-write on the 50th RUN clock -> PASS, timeout=0.
REQ-039 rst pulsed 1 clock mid-RUN and in PASS -> all outputs return to reset values, RST_CYCLES sequence restarts.
REQ-040 RUN_CTRL_INSTRET_EN, CNT_W=4, retire_valid held high 30 RUN clocks -> instret=15 (saturated), cycle_cnt=15.
